// File: rtl/cell_ram_pkg.sv
// cell_ram_pkg: shared constants, register layout and helpers for the
// CellularRAM (PSRAM) behavioural target.
package cell_ram_pkg;

    // Register select codes carried on addr[REG_SEL+1:REG_SEL]
    localparam logic [1:0] SEL_BCR = 2'd2;
    localparam logic [1:0] SEL_RCR = 2'd0;

    // Power-up / reset contents of the configuration registers
    localparam logic [15:0] BCR_RESET = 16'h9D1F;
    localparam logic [15:0] RCR_RESET = 16'h0010;

    // Bus Configuration Register field positions
    localparam int BCR_MODE       = 15;  // 1 = asynchronous, 0 = synchronous burst
    localparam int BCR_LATFIX     = 14;  // 1 = fixed latency (same timing here)
    localparam int BCR_LC_HI      = 13;  // latency code, upper bit
    localparam int BCR_LC_LO      = 11;  // latency code, lower bit
    localparam int BCR_WAITPOL    = 10;  // 1 = WAIT active high
    localparam int BCR_WAITEARLY  = 8;   // 1 = WAIT released one cycle ahead of data
    localparam int BCR_NOWRAP     = 3;   // 1 = linear burst, 0 = wrap in block
    localparam int BCR_BL_HI      = 2;   // burst length code, upper bit
    localparam int BCR_BL_LO      = 0;   // burst length code, lower bit

    // Burst engine states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LAT  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Burst length in words; zero means continuous
    function automatic logic [5:0] burstLen(input logic [2:0] code);
        logic [5:0] len;
        case (code)
            3'd1:    len = 6'd4;
            3'd2:    len = 6'd8;
            3'd3:    len = 6'd16;
            3'd4:    len = 6'd32;
            default: len = 6'd0;
        endcase
        return len;
    endfunction

    // Latency in clock edges between the address edge and word 0
    function automatic logic [3:0] latCycles(input logic [2:0] code);
        return (code == 3'd0) ? 4'd8 : {1'b0, code};
    endfunction

endpackage

// File: rtl/cell_ram_burst_addr.sv
// cell_ram_burst_addr: word-k address generator for synchronous bursts.
// Fixed-length bursts with wrap enabled stay inside their length-aligned
// block; otherwise the address simply increments and rolls over at the top
// of the implemented array.
module cell_ram_burst_addr
    import cell_ram_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic [AW-1:0] i_start,
    input  logic [2:0]    i_lenCode,
    input  logic          i_noWrap,
    input  logic [AW-1:0] i_index,
    output logic [AW-1:0] o_addr
);

    logic [5:0]    w_len;
    logic [AW-1:0] w_linear;
    logic [AW-1:0] w_mask;

    // Combine the block base with the incremented offset when wrapping
    always_comb begin
        w_len    = burstLen(i_lenCode);
        w_linear = i_start + i_index;
        w_mask   = AW'(w_len - 6'd1);
        o_addr   = w_linear;
        if ((w_len != 6'd0) && !i_noWrap) begin
            o_addr = (i_start & ~w_mask) | (w_linear & w_mask);
        end
    end

endmodule

// File: rtl/cell_ram.sv
// cell_ram: cycle-based 16-bit CellularRAM model with async single-word
// access, synchronous bursts with programmable latency, BCR/RCR config
// registers and a WAIT pin. The array is never reset.
module cell_ram
    import cell_ram_pkg::*;
#(
    parameter int ADDR_BITS = 23,
    parameter int DQ_BITS   = 16,
    parameter int BY_BITS   = 2,
    parameter int MEM_WORDS = 1024,
    parameter int REG_SEL   = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adv_n,
    input  logic                 cre,
    input  logic                 ce_n,
    input  logic                 oe_n,
    input  logic                 we_n,
    input  logic                 ub_n,
    input  logic                 lb_n,
    input  logic [ADDR_BITS-1:0] addr,
    inout  wire  [DQ_BITS-1:0]   dq,
    output logic                 o_wait
);

    localparam int MEM_AW = $clog2(MEM_WORDS);

    logic [DQ_BITS-1:0] r_mem [MEM_WORDS];

    logic [DQ_BITS-1:0] r_bcr;
    logic [DQ_BITS-1:0] r_rcr;

    state_t             r_state;
    state_t             w_stateNext;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cntNext;
    logic [MEM_AW-1:0]  r_k;
    logic [MEM_AW-1:0]  w_kNext;
    logic               r_burstDone;
    logic               w_burstDoneNext;

    logic [MEM_AW-1:0]  r_start;
    logic               r_dirWrite;
    logic               r_cfg;
    logic [1:0]         r_cfgSel;

    logic               r_wait;
    logic               r_dqOe;
    logic [DQ_BITS-1:0] r_dqOut;

    logic               w_sync;
    logic               w_early;
    logic               w_pol;
    logic [3:0]         w_lc;
    logic [5:0]         w_len;
    logic               w_cfgWrite;
    logic [1:0]         w_sel;
    logic [1:0]         w_curSel;
    logic               w_curCfg;
    logic [MEM_AW-1:0]  w_curAddr;
    logic [MEM_AW-1:0]  w_burstAddr;
    logic [MEM_AW-1:0]  w_memAddr;
    logic               w_waitAct;
    logic               w_dataEdge;
    logic               w_asyncWe;
    logic               w_syncWe;
    logic               w_memWe;
    logic [BY_BITS-1:0] w_be;
    logic [DQ_BITS-1:0] w_syncRegVal;
    logic [DQ_BITS-1:0] w_asyncRegVal;
    logic               w_unusedBits;

    // Decoded configuration fields and pin-level qualifiers
    assign w_sync     = ~r_bcr[BCR_MODE];
    assign w_early    = r_bcr[BCR_WAITEARLY];
    assign w_pol      = r_bcr[BCR_WAITPOL];
    assign w_lc       = latCycles(r_bcr[BCR_LC_HI:BCR_LC_LO]);
    assign w_len      = burstLen(r_bcr[BCR_BL_HI:BCR_BL_LO]);
    assign w_sel      = addr[REG_SEL+1:REG_SEL];
    assign w_cfgWrite = ~ce_n & cre & ~adv_n & ~we_n;
    assign w_be       = {~ub_n, ~lb_n};

    // In async mode an edge with adv_n low uses the address on the pins
    // directly; otherwise the previously latched address is current.
    assign w_curAddr  = adv_n ? r_start  : addr[MEM_AW-1:0];
    assign w_curSel   = adv_n ? r_cfgSel : w_sel;
    assign w_curCfg   = adv_n ? r_cfg    : cre;

    assign w_unusedBits = ^{addr[ADDR_BITS-1:REG_SEL+2], addr[REG_SEL-1:DQ_BITS],
                            r_bcr[BCR_LATFIX], r_bcr[9], r_bcr[7:4]};

    cell_ram_burst_addr #(
        .AW (MEM_AW)
    ) u_burstAddr (
        .i_start   (r_start),
        .i_lenCode (r_bcr[BCR_BL_HI:BCR_BL_LO]),
        .i_noWrap  (r_bcr[BCR_NOWRAP]),
        .i_index   (r_k),
        .o_addr    (w_burstAddr)
    );

    // Register read mux for both the latched (burst) and current (async) selects
    always_comb begin
        w_syncRegVal  = '0;
        w_asyncRegVal = '0;
        if (r_cfgSel == SEL_BCR) begin
            w_syncRegVal = r_bcr;
        end else if (r_cfgSel == SEL_RCR) begin
            w_syncRegVal = r_rcr;
        end
        if (w_curSel == SEL_BCR) begin
            w_asyncRegVal = r_bcr;
        end else if (w_curSel == SEL_RCR) begin
            w_asyncRegVal = r_rcr;
        end
    end

    // Burst engine next state, WAIT level for the coming cycle and data-edge flag
    always_comb begin
        w_stateNext     = r_state;
        w_cntNext       = r_cnt;
        w_kNext         = r_k;
        w_burstDoneNext = r_burstDone;
        w_waitAct       = 1'b0;
        w_dataEdge      = 1'b0;
        if (ce_n || !w_sync) begin
            w_stateNext     = ST_IDLE;
            w_burstDoneNext = 1'b0;
        end else if (!adv_n) begin
            w_kNext         = '0;
            w_cntNext       = 4'd1;
            w_burstDoneNext = 1'b0;
            if (cre && !we_n) begin
                w_stateNext = ST_IDLE;
            end else if (w_lc == 4'd1) begin
                w_stateNext = ST_DATA;
                w_waitAct   = !w_early;
            end else begin
                w_stateNext = ST_LAT;
                w_waitAct   = 1'b1;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_waitAct = r_burstDone;
                end
                ST_LAT: begin
                    if (r_cnt == (w_lc - 4'd1)) begin
                        w_stateNext = ST_DATA;
                        w_waitAct   = !w_early;
                    end else begin
                        w_cntNext = r_cnt + 4'd1;
                        w_waitAct = 1'b1;
                    end
                end
                ST_DATA: begin
                    w_dataEdge = 1'b1;
                    w_kNext    = r_k + MEM_AW'(1);
                    if ((w_len != 6'd0) && (r_k == MEM_AW'(w_len - 6'd1))) begin
                        w_stateNext     = ST_IDLE;
                        w_burstDoneNext = 1'b1;
                    end
                end
                default: begin
                    w_stateNext = ST_IDLE;
                end
            endcase
        end
    end

    // Array write qualification; nothing reaches the array while rst is high
    assign w_asyncWe = ~w_sync & ~ce_n & ~we_n & ~w_curCfg;
    assign w_syncWe  = w_sync & w_dataEdge & r_dirWrite & ~r_cfg;
    assign w_memWe   = ~rst & (w_asyncWe | w_syncWe);
    assign w_memAddr = w_sync ? w_burstAddr : w_curAddr;

    // Burst engine state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_k         <= '0;
            r_burstDone <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_cnt       <= w_cntNext;
            r_k         <= w_kNext;
            r_burstDone <= w_burstDoneNext;
        end
    end

    // Configuration registers: reset to defaults, loaded from the address bus
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcr <= BCR_RESET;
            r_rcr <= RCR_RESET;
        end else if (w_cfgWrite) begin
            if (w_sel == SEL_BCR) begin
                r_bcr <= addr[DQ_BITS-1:0];
            end else if (w_sel == SEL_RCR) begin
                r_rcr <= addr[DQ_BITS-1:0];
            end
        end
    end

    // Address, direction and register-target capture on every adv_n-low edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start    <= '0;
            r_dirWrite <= 1'b0;
            r_cfg      <= 1'b0;
            r_cfgSel   <= 2'd0;
        end else if (!adv_n) begin
            r_start    <= addr[MEM_AW-1:0];
            r_dirWrite <= ~we_n;
            r_cfg      <= cre;
            r_cfgSel   <= w_sel;
        end
    end

    // Byte-lane masked array write; contents survive reset
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            for (int b = 0; b < BY_BITS; b++) begin
                if (w_be[b]) begin
                    r_mem[w_memAddr][b*8 +: 8] <= dq[b*8 +: 8];
                end
            end
        end
    end

    // Registered dq and WAIT outputs for both access modes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dqOe  <= 1'b0;
            r_dqOut <= '0;
            r_wait  <= 1'b0;
        end else begin
            r_wait <= w_waitAct ? w_pol : ~w_pol;
            if (w_sync) begin
                r_dqOe  <= w_dataEdge & ~r_dirWrite & ~oe_n;
                r_dqOut <= r_cfg ? w_syncRegVal : r_mem[w_burstAddr];
            end else begin
                r_dqOe  <= ~ce_n & ~oe_n & we_n;
                r_dqOut <= w_curCfg ? w_asyncRegVal : r_mem[w_curAddr];
            end
        end
    end

    assign dq     = r_dqOe ? r_dqOut : 'z;
    assign o_wait = r_wait;

endmodule

// File: tb/tb_cell_ram.sv
// tb_cell_ram: directed self-checking bench for cell_ram covering async
// access, configuration registers, synchronous bursts, WAIT timing,
// wrap/linear addressing and reset during a burst.
module tb_cell_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        advN;
    logic        cre;
    logic        ceN;
    logic        oeN;
    logic        weN;
    logic        ubN;
    logic        lbN;
    logic [22:0] addr;
    logic        oWait;
    wire  [15:0] dq;

    logic        tbDrive;
    logic [15:0] tbData;

    int total = 0;
    int bad   = 0;

    assign dq = tbDrive ? tbData : 'z;

    always #5 clk = ~clk;

    cell_ram dut (
        .clk    (clk),
        .rst    (rst),
        .adv_n  (advN),
        .cre    (cre),
        .ce_n   (ceN),
        .oe_n   (oeN),
        .we_n   (weN),
        .ub_n   (ubN),
        .lb_n   (lbN),
        .addr   (addr),
        .dq     (dq),
        .o_wait (oWait)
    );

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive all control pins, then let one rising edge sample them
    task automatic applyStimulus(input logic iAdvN, input logic iCre, input logic iCeN,
                                 input logic iOeN, input logic iWeN, input logic iUbN,
                                 input logic iLbN, input logic [22:0] iAddr);
        advN = iAdvN;
        cre  = iCre;
        ceN  = iCeN;
        oeN  = iOeN;
        weN  = iWeN;
        ubN  = iUbN;
        lbN  = iLbN;
        addr = iAddr;
        tick();
    endtask

    // Count one comparison and report it if it does not match
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive a known pattern onto dq; it only reads back intact if the DUT is off the bus
    task automatic probeHiZ(input string tag);
        tbData  = 16'hA5A5;
        tbDrive = 1'b1;
        #1;
        checkOutput(tag, 32'(dq), 32'h0000A5A5);
        tbDrive = 1'b0;
    endtask

    task automatic deselect();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 23'h0);
    endtask

    task automatic cfgWrite(input logic [15:0] val);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 23'h080000 | 23'(val));
        deselect();
    endtask

    task automatic asyncWrite(input logic [22:0] a, input logic [15:0] d,
                              input logic iUbN, input logic iLbN);
        tbData  = d;
        tbDrive = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, iUbN, iLbN, a);
        tbDrive = 1'b0;
        deselect();
    endtask

    task automatic asyncRead(input string tag, input logic [22:0] a, input logic [15:0] exp);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a);
        checkOutput(tag, 32'(dq), 32'(exp));
        deselect();
    endtask

    // Sync read of four words at LC=3; words packed first-word-high
    task automatic readBurst(input string tag, input logic [22:0] a,
                             input logic [63:0] words, input logic early);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a);
        checkOutput({tag, "_wait_e0"}, 32'(oWait), 32'd1);
        probeHiZ({tag, "_dq_e0"});
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a);
        checkOutput({tag, "_wait_e1"}, 32'(oWait), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a);
        checkOutput({tag, "_wait_e2"}, 32'(oWait), early ? 32'd0 : 32'd1);
        probeHiZ({tag, "_dq_e2"});
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a);
            checkOutput($sformatf("%s_d%0d", tag, k), 32'(dq), 32'(words[63-16*k -: 16]));
            checkOutput($sformatf("%s_wait_d%0d", tag, k), 32'(oWait), 32'd0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        advN    = 1'b1;
        cre     = 1'b0;
        ceN     = 1'b1;
        oeN     = 1'b1;
        weN     = 1'b1;
        ubN     = 1'b1;
        lbN     = 1'b1;
        addr    = 23'h0;
        tbDrive = 1'b0;
        tbData  = 16'h0;
        tick();
        tick();
        checkOutput("rst_wait", 32'(oWait), 32'd0);
        probeHiZ("rst_dq");
        rst = 1'b0;
        tick();

        $display("[TB] async access");
        asyncWrite(23'h10, 16'h1234, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 23'h10);
        checkOutput("async_rd", 32'(dq), 32'h1234);
        checkOutput("async_wait", 32'(oWait), 32'd0);
        deselect();
        asyncWrite(23'h10, 16'hABCD, 1'b1, 1'b0);
        asyncRead("async_lb_only", 23'h10, 16'h12CD);
        asyncRead("async_alias", 23'h410, 16'h12CD);

        $display("[TB] configuration registers");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 23'h080000);
        checkOutput("bcr_reset", 32'(dq), 32'h9D1F);
        deselect();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 23'h000000);
        checkOutput("rcr_reset", 32'(dq), 32'h0010);
        deselect();
        cfgWrite(16'h1D1F);
        checkOutput("desel_wait", 32'(oWait), 32'd0);
        probeHiZ("desel_dq");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 23'h080000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 23'h0);
        end
        checkOutput("bcr_sync", 32'(dq), 32'h1D1F);
        deselect();

        $display("[TB] sync write burst");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h20);
        checkOutput("wr_wait_e0", 32'(oWait), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h20);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h20);
        checkOutput("wr_wait_e2", 32'(oWait), 32'd0);
        tbDrive = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tbData = 16'h1111 * 16'(k + 1);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h20);
        end
        tbDrive = 1'b0;
        deselect();

        $display("[TB] sync read bursts");
        readBurst("rd_early", 23'h20, 64'h1111_2222_3333_4444, 1'b1);
        deselect();
        probeHiZ("rd_desel_dq");
        checkOutput("rd_desel_wait", 32'(oWait), 32'd0);
        cfgWrite(16'h1C1F);
        readBurst("rd_late", 23'h20, 64'h1111_2222_3333_4444, 1'b0);
        deselect();

        cfgWrite(16'h1D11);
        readBurst("wrap", 23'h22, 64'h3333_4444_1111_2222, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 23'h22);
        checkOutput("wrap_end_wait", 32'(oWait), 32'd1);
        probeHiZ("wrap_end_dq");
        deselect();

        cfgWrite(16'h1D19);
        readBurst("linear", 23'h22, 64'h3333_4444_5555_6666, 1'b1);
        deselect();

        $display("[TB] reset during sync write");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h20);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h20);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h20);
        tbDrive = 1'b1;
        tbData  = 16'hAAAA;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h20);
        tbData  = 16'hBBBB;
        rst     = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 23'h20);
        tbDrive = 1'b0;
        deselect();
        checkOutput("rstmid_wait", 32'(oWait), 32'd0);
        probeHiZ("rstmid_dq");
        rst = 1'b0;
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 23'h080000);
        checkOutput("rstmid_bcr", 32'(dq), 32'h9D1F);
        deselect();
        asyncRead("rstmid_w0", 23'h20, 16'hAAAA);
        asyncRead("rstmid_w1", 23'h21, 16'h2222);
        asyncRead("rstmid_w2", 23'h22, 16'h3333);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
